// File: rtl/ram_arb_pkg.sv
// Shared types for the frame-RAM arbiter: bus widths and the read-return tag.
// The tag travels alongside the RAM read so data returns to the requester that asked for it.
package ram_arb_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;

  typedef enum logic {OWN_P0, OWN_P1} owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   oor;
  } rd_tag_t;

  function automatic logic addr_oor(input logic [31:0] addr, input logic [31:0] depth);
    return addr >= depth;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle of the frame-RAM arbiter: scan-out read port and editor read/write port.
// master = requester logic, slave = arbiter.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);

  logic              p0_req;
  logic [ADDR_W-1:0] p0_addr;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  modport master (
    output p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata
  );

  modport slave (
    input  p0_req, p0_addr, p1_req, p1_we, p1_addr, p1_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p1_gnt, p1_rvalid, p1_rdata
  );

endinterface

// File: rtl/ram_port_arbiter_rd_tag_pipe.sv
// Fixed-length shift register of read tags; output appears LEN cycles after input.
// No backpressure: one tag enters every cycle (invalid tags fill idle slots).
module rd_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int LEN = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t din,
  output rd_tag_t dout
);

  rd_tag_t [LEN-1:0] stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage <= {stage[LEN-2:0], din};
    end
  end

  assign dout = stage[LEN-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Fixed-priority arbiter (port 0 first, starvation guard for port 1) in front of a single-port RAM.
// Grants are combinational; RAM inputs registered one cycle later; reads return after 1+RD_LAT cycles.
module ram_port_arbiter #(
  parameter int ADDR_W     = ram_arb_pkg::ADDR_W,
  parameter int DATA_W     = ram_arb_pkg::DATA_W,
  parameter int DEPTH      = 32768,
  parameter int RD_LAT     = 1,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  import ram_arb_pkg::*;

  localparam logic [3:0]  MAX_S   = 4'(MAX_STARVE);
  localparam logic [31:0] DEPTH_L = 32'(DEPTH);

  logic              gnt0;
  logic              gnt1;
  logic              p0_oor;
  logic              p1_oor;
  logic [3:0]        starve_cnt;
  rd_tag_t           tag_in;
  rd_tag_t           tag_out;
  logic              p0_hit;
  logic              p1_hit;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] p0_hold;
  logic [DATA_W-1:0] p1_hold;

  assign p0_oor = addr_oor(32'(bus.p0_addr), DEPTH_L);
  assign p1_oor = addr_oor(32'(bus.p1_addr), DEPTH_L);

  // Grants are forced low during reset so every output reads 0 while rst is high.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (bus.p1_req && (!bus.p0_req || starve_cnt == MAX_S)) begin
        gnt1 = 1'b1;
      end else if (bus.p0_req) begin
        gnt0 = 1'b1;
      end
    end
  end

  assign bus.p0_gnt = gnt0;
  assign bus.p1_gnt = gnt1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (bus.p1_req && gnt0) begin
      if (starve_cnt != MAX_S) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
    end else begin
      ram_wren <= gnt1 && bus.p1_we && !p1_oor;
      if (gnt0) begin
        ram_address <= bus.p0_addr;
      end else if (gnt1) begin
        ram_address <= bus.p1_addr;
      end
      if (gnt1 && bus.p1_we) begin
        ram_data <= bus.p1_wdata;
      end
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = gnt0 || (gnt1 && !bus.p1_we);
    tag_in.owner = gnt1 ? OWN_P1 : OWN_P0;
    tag_in.oor   = gnt1 ? p1_oor : p0_oor;
  end

  // One extra stage covers the address register in front of the RAM.
  rd_tag_pipe #(
    .LEN (1 + RD_LAT)
  ) u_tag_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

  assign p0_hit = tag_out.valid && (tag_out.owner == OWN_P0);
  assign p1_hit = tag_out.valid && (tag_out.owner == OWN_P1);
  assign rd_val = tag_out.oor ? '0 : ram_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_hold <= '0;
      p1_hold <= '0;
    end else begin
      if (p0_hit) p0_hold <= rd_val;
      if (p1_hit) p1_hold <= rd_val;
    end
  end

  assign bus.p0_rvalid = p0_hit;
  assign bus.p1_rvalid = p1_hit;
  assign bus.p0_rdata  = p0_hit ? rd_val : p0_hold;
  assign bus.p1_rdata  = p1_hit ? rd_val : p1_hold;

endmodule
